// File: rtl/ad9228_serial_tx.sv
// ad9228_serial_tx: AD9228-format serializing transmitter (single-ended side).
// Parallel samples arrive on a valid/ready stream. Each one is sent MSB first on
// one lane per channel, together with the frame clock (fco) and the data clock (dco).
//
// Ports:
//   clk          bit clock, one serial bit per cycle
//   rstn         synchronous active-low reset
//   tx_en        transmit enable; a frame in progress always completes
//   test_mode    selects the internal ramp source (only with AD9228_TX_RAMP_EN)
//   s_data       channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_valid      s_data valid
//   s_ready      word accepted when s_valid && s_ready
//   dout         serial data per channel, MSB first
//   fco          frame clock, high for the first half of each frame
//   dco          data clock, clk/2, toggles while running
//   underrun_cnt saturating count of repeated frames (no fresh data)
//
// Build option: define AD9228_TX_RAMP_EN to include the per-channel ramp generator.
module ad9228_serial_tx #(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned DATA_WIDTH   = 12
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               tx_en,
    input  logic                               test_mode,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    output logic [NUM_CHANNELS-1:0]            dout,
    output logic                               fco,
    output logic                               dco,
    output logic [15:0]                        underrun_cnt
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam int unsigned LAST  = DATA_WIDTH - 1;
    localparam int unsigned HALF  = DATA_WIDTH / 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    typedef logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] frame_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    frame_t           shift_q, word_q, word_in;
    logic             load_word, load_rep, do_shift, do_clear, inc_under;
    logic             ramp_sel, at_last, fco_d, dco_d;

    assign at_last = (bit_cnt_q == CNT_W'(LAST));

`ifdef AD9228_TX_RAMP_EN
    // Ramp source: channel i starts at i and advances once per frame it supplies.
    frame_t ramp_q;

    assign ramp_sel = test_mode;
    assign word_in  = ramp_sel ? ramp_q : frame_t'(s_data);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                ramp_q[i] <= DATA_WIDTH'(i);
            end
        end else if (load_word && ramp_sel) begin
            for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                ramp_q[i] <= ramp_q[i] + DATA_WIDTH'(1);
            end
        end
    end
`else
    logic unused_test_mode;

    assign unused_test_mode = test_mode;
    assign ramp_sel         = 1'b0;
    assign word_in          = frame_t'(s_data);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next state, handshake and datapath controls
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        load_word = 1'b0;
        load_rep  = 1'b0;
        do_shift  = 1'b0;
        do_clear  = 1'b0;
        inc_under = 1'b0;
        s_ready   = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx_en) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                s_ready = !ramp_sel;
                // A handshake offered while s_ready=1 is always honoured.
                if (ramp_sel ? tx_en : s_valid) begin
                    load_word = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = RUN;
                end else if (!tx_en) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (at_last) begin
                    bit_cnt_d = '0;
                    if (!tx_en) begin
                        do_clear = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        s_ready = !ramp_sel;
                        if (ramp_sel || s_valid) begin
                            load_word = 1'b1;
                        end else begin
                            load_rep  = 1'b1;
                            inc_under = 1'b1;
                        end
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    do_shift  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        fco_d = (state_d == RUN) && (bit_cnt_d < CNT_W'(HALF));
        // dco starts low in the first RUN cycle and then free-runs across frames.
        dco_d = (state_d == RUN) && (state_q == RUN) && !dco;
    end

    // Shift registers, frame clocks and underrun counter
    always_ff @(posedge clk) begin
        if (!rstn) begin
            shift_q      <= '0;
            word_q       <= '0;
            fco          <= 1'b0;
            dco          <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            fco <= fco_d;
            dco <= dco_d;
            if (load_word) begin
                shift_q <= word_in;
                word_q  <= word_in;
            end else if (load_rep) begin
                shift_q <= word_q;
            end else if (do_clear) begin
                shift_q <= '0;
            end else if (do_shift) begin
                for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
                    shift_q[i] <= {shift_q[i][DATA_WIDTH-2:0], 1'b0};
                end
            end
            if (inc_under && (underrun_cnt != 16'hFFFF)) begin
                underrun_cnt <= underrun_cnt + 16'd1;
            end
        end
    end

    // Shift registers are cleared outside RUN, so the MSBs are quiet there.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            dout[i] = shift_q[i][DATA_WIDTH-1];
        end
    end

endmodule

// File: tb/tb_ad9228_serial_tx.sv
// Testbench for ad9228_serial_tx: hand-computed vector table, directed corner
// sequences and randomized frame streams checked against a frame-level model.
module tb_ad9228_serial_tx;

    localparam int unsigned NCH = 4;
    localparam int unsigned DW  = 12;
    localparam int unsigned FW  = NCH * DW;

`ifdef AD9228_TX_RAMP_EN
    localparam bit TM_NORMAL = 1'b0;
`else
    localparam bit TM_NORMAL = 1'b1;   // ramp absent: test_mode must be ignored
`endif

    logic           clk = 1'b0;
    logic           rstn, tx_en, test_mode, s_valid, s_ready, fco, dco;
    logic [FW-1:0]  s_data;
    logic [NCH-1:0] dout;
    logic [15:0]    underrun_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int ucnt_exp = 0;

    logic [FW-1:0] fr_word[$];
    bit            fr_new[$];

    typedef struct {
        logic [FW-1:0]            data;
        logic [DW-1:0][NCH-1:0]   exp_dout;   // element k = lanes during bit k
        logic [DW-1:0]            exp_fco;    // bit k = fco during bit k
    } vec_t;

    vec_t vecs[2];

    ad9228_serial_tx #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn(rstn), .tx_en(tx_en), .test_mode(test_mode),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .dout(dout), .fco(fco), .dco(dco), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_dout"}, 64'(dout), 64'(0));
        chk({name, "_fco"}, 64'(fco), 64'(0));
        chk({name, "_dco"}, 64'(dco), 64'(0));
        chk({name, "_ready"}, 64'(s_ready), 64'(0));
    endtask

    // Lane values expected while bit k (0 = MSB) of word w is on the wire.
    function automatic logic [NCH-1:0] exp_bits(input logic [FW-1:0] w, input int k);
        logic [NCH-1:0] r;
        for (int c = 0; c < NCH; c++) r[c] = w[c*DW + (DW-1-k)];
        return r;
    endfunction

    function automatic int sat16(input int x);
        return (x > 65535) ? 65535 : x;
    endfunction

    // Send the frames queued in fr_word/fr_new starting from IDLE, then stop.
    // fr_new[f]=0 means no data offered at that boundary, so the previous word repeats.
    task automatic run_stream(input string name);
        int            nf = fr_new.size();
        logic [FW-1:0] cur;
        tx_en = 1'b1;
        step();
        chk({name, "_prime_ready"}, 64'(s_ready), 64'(1));
        s_valid = 1'b1;
        s_data  = fr_word[0];
        cur     = fr_word[0];
        step();
        for (int f = 0; f < nf; f++) begin
            if (f > 0) begin
                if (fr_new[f]) cur = fr_word[f];
                else ucnt_exp = sat16(ucnt_exp + 1);
            end
            chk({name, "_underrun"}, 64'(underrun_cnt), 64'(ucnt_exp));
            for (int k = 0; k < int'(DW); k++) begin
                chk({name, "_dout"}, 64'(dout), 64'(exp_bits(cur, k)));
                chk({name, "_fco"}, 64'(fco), 64'(k < int'(DW/2)));
                chk({name, "_dco"}, 64'(dco), 64'(k % 2));
                if (k == int'(DW) - 1) begin
                    if (f + 1 < nf) begin
                        s_valid = fr_new[f+1];
                        s_data  = fr_new[f+1] ? fr_word[f+1] : {$urandom, $urandom};
                    end else begin
                        // tx_en falls together with s_valid: word must be refused
                        tx_en   = 1'b0;
                        s_valid = 1'b1;
                        s_data  = {$urandom, $urandom};
                    end
                end else begin
                    s_valid = 1'($urandom % 2);       // ignored mid-frame
                    s_data  = {$urandom, $urandom};
                end
                #1;
                chk({name, "_ready"}, 64'(s_ready), 64'((k == int'(DW) - 1) && (f + 1 < nf)));
                step();
            end
        end
        s_valid = 1'b0;
        chk_quiet({name, "_end"});
        chk({name, "_underrun_end"}, 64'(underrun_cnt), 64'(ucnt_exp));
        fr_word.delete();
        fr_new.delete();
    endtask

    // Start one frame of word w from IDLE; returns with bit 0 on the wire.
    task automatic start_frame(input logic [FW-1:0] w);
        tx_en = 1'b1;
        step();
        s_valid = 1'b1;
        s_data  = w;
        step();
        s_valid = 1'b0;
    endtask

    initial begin
        logic [FW-1:0] w;
        int            nf;

        vecs[0].data     = 48'h000_000_FFF_A5C;
        vecs[0].exp_dout = 48'h2233_3232_2323;
        vecs[0].exp_fco  = 12'h03F;
        vecs[1].data     = 48'h555_F0F_001_800;
        vecs[1].exp_dout = 48'hE4C4_8080_C4C5;
        vecs[1].exp_fco  = 12'h03F;

        rstn = 1'b0; tx_en = 1'b1; test_mode = TM_NORMAL; s_valid = 1'b0; s_data = '0;

        // Reset held with tx_en high
        repeat (3) step();
        chk_quiet("reset");
        chk("reset_underrun", 64'(underrun_cnt), 64'(0));
        tx_en = 1'b0;
        rstn  = 1'b1;
        step();
        chk_quiet("idle");

        // Single-word vectors
        for (int v = 0; v < 2; v++) begin
            tx_en = 1'b1;
            step();
            chk("vec_prime_ready", 64'(s_ready), 64'(1));
            s_valid = 1'b1;
            s_data  = vecs[v].data;
            step();
            s_valid = 1'b0;
            for (int k = 0; k < int'(DW); k++) begin
                chk("vec_dout", 64'(dout), 64'(vecs[v].exp_dout[k]));
                chk("vec_fco", 64'(fco), 64'(vecs[v].exp_fco[k]));
                if (k == int'(DW) - 1) tx_en = 1'b0;
                step();
            end
            chk_quiet("vec_idle");
        end

        // Back-to-back: four fresh words
        for (int f = 0; f < 4; f++) begin
            fr_word.push_back({$urandom, $urandom});
            fr_new.push_back(1'b1);
        end
        run_stream("b2b");

        // Underrun: 0x123 then two frames with no data
        w = {$urandom, $urandom};
        w[DW-1:0] = 12'h123;
        fr_word.push_back(w);     fr_new.push_back(1'b1);
        fr_word.push_back('0);    fr_new.push_back(1'b0);
        fr_word.push_back('0);    fr_new.push_back(1'b0);
        run_stream("underrun");
        chk("underrun_two", 64'(underrun_cnt), 64'(2));

        // Random streams
        for (int r = 0; r < 6; r++) begin
            nf = 3 + int'($urandom % 5);
            for (int f = 0; f < nf; f++) begin
                fr_word.push_back({$urandom, $urandom});
                fr_new.push_back((f == 0) ? 1'b1 : 1'($urandom % 2));
            end
            run_stream("rand");
        end

        // tx_en drops at bit 5: frame still completes
        w = {$urandom, $urandom};
        start_frame(w);
        for (int k = 0; k < int'(DW); k++) begin
            chk("dis_dout", 64'(dout), 64'(exp_bits(w, k)));
            if (k == 5) tx_en = 1'b0;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            chk_quiet("dis_idle");
            step();
        end

        // Saturation near the top of the counter range
        force dut.underrun_cnt = 16'hFFFD;
        #1;
        release dut.underrun_cnt;
        ucnt_exp = 16'hFFFD;
        fr_word.push_back({$urandom, $urandom});
        fr_new.push_back(1'b1);
        for (int f = 0; f < 4; f++) begin
            fr_word.push_back('0);
            fr_new.push_back(1'b0);
        end
        run_stream("sat");
        chk("sat_hold", 64'(underrun_cnt), 64'(16'hFFFF));

        // Reset at bit 5 of a frame
        w = {$urandom, $urandom};
        start_frame(w);
        for (int k = 0; k < 5; k++) begin
            chk("rst_dout", 64'(dout), 64'(exp_bits(w, k)));
            step();
        end
        rstn = 1'b0;
        step();
        chk_quiet("rst_mid");
        chk("rst_mid_underrun", 64'(underrun_cnt), 64'(0));
        rstn  = 1'b1;
        tx_en = 1'b0;
        step();
        chk_quiet("rst_after");
        ucnt_exp = 0;

`ifdef AD9228_TX_RAMP_EN
        // Ramp: channel c sends (c + f) mod 2^DW in frame f, including the wrap.
        test_mode = 1'b1;
        tx_en     = 1'b1;
        s_valid   = 1'b1;
        step();
        chk("ramp_prime_ready", 64'(s_ready), 64'(0));
        step();
        nf = 4095;
        for (int f = 0; f < nf; f++) begin
            for (int c = 0; c < int'(NCH); c++) w[c*DW +: DW] = DW'(c + f);
            for (int k = 0; k < int'(DW); k++) begin
                chk("ramp_dout", 64'(dout), 64'(exp_bits(w, k)));
                if (k == int'(DW) - 1 && f == nf - 1) tx_en = 1'b0;
                chk("ramp_ready", 64'(s_ready), 64'(0));
                step();
            end
        end
        chk_quiet("ramp_end");
        chk("ramp_underrun", 64'(underrun_cnt), 64'(0));
        test_mode = 1'b0;
        s_valid   = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
